// File: rtl/beu_pipe.sv
// beu_pipe: two-stage branch execution unit with an in-order result FIFO.
// EX1 resolves the branch condition and forms target/link; EX2 derives
// next-PC, mispredict and misalignment and pushes the result into a small
// FIFO that feeds the ROB/redirect logic under credit-based flow control.
module beu_pipe #(
    parameter int DATA_LEN    = 32,
    parameter int ROB_TAG_LEN = 6,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                   clk_free_master,
    input  logic                   global_rst,
    input  logic                   flush,
    input  logic                   valid_ex1,
    output logic                   ready_ex1,
    input  logic [2:0]             br_func_ex1,
    input  logic [DATA_LEN-1:0]    pc_ex1,
    input  logic [DATA_LEN-1:0]    rs1_ex1,
    input  logic [DATA_LEN-1:0]    rs2_ex1,
    input  logic [DATA_LEN-1:0]    imm_ex1,
    input  logic                   pred_taken_ex1,
    input  logic [DATA_LEN-1:0]    pred_target_ex1,
    input  logic [ROB_TAG_LEN-1:0] rob_tag_ex1,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ROB_TAG_LEN-1:0] res_tag,
    output logic                   res_taken,
    output logic [DATA_LEN-1:0]    res_next_pc,
    output logic [DATA_LEN-1:0]    res_link,
    output logic                   res_mispredict,
    output logic                   res_misalign
);

    localparam int PTR_W   = $clog2(OUT_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    // {tag, taken, next_pc, link, mispredict, misalign}
    localparam int ENTRY_W = ROB_TAG_LEN + 3 + 2 * DATA_LEN;

    localparam logic [2:0] F_BEQ  = 3'b000;
    localparam logic [2:0] F_BNE  = 3'b001;
    localparam logic [2:0] F_JAL  = 3'b010;
    localparam logic [2:0] F_JALR = 3'b011;
    localparam logic [2:0] F_BLT  = 3'b100;
    localparam logic [2:0] F_BGE  = 3'b101;
    localparam logic [2:0] F_BLTU = 3'b110;
    localparam logic [2:0] F_BGEU = 3'b111;

    // Branch condition; jumps are unconditionally taken.
    function automatic logic br_taken(input logic [2:0]          func,
                                      input logic [DATA_LEN-1:0] a,
                                      input logic [DATA_LEN-1:0] b);
        logic signed [DATA_LEN-1:0] sa;
        logic signed [DATA_LEN-1:0] sb;
        logic                       t;
        sa = a;
        sb = b;
        t  = 1'b1;
        case (func)
            F_BEQ:         t = (a == b);
            F_BNE:         t = (a != b);
            F_BLT:         t = (sa < sb);
            F_BGE:         t = (sa >= sb);
            F_BLTU:        t = (a < b);
            F_BGEU:        t = (a >= b);
            F_JAL, F_JALR: t = 1'b1;
        endcase
        return t;
    endfunction

    // Branch target; JALR is register-relative with bit 0 forced low.
    function automatic logic [DATA_LEN-1:0] br_target(input logic [2:0]          func,
                                                      input logic [DATA_LEN-1:0] pc,
                                                      input logic [DATA_LEN-1:0] rs1,
                                                      input logic [DATA_LEN-1:0] imm);
        logic [DATA_LEN-1:0] sum;
        if (func == F_JALR) begin
            sum    = rs1 + imm;
            sum[0] = 1'b0;
        end else begin
            sum = pc + imm;
        end
        return sum;
    endfunction

    // ------------------------------------------------------------------
    // EX1 (p0): condition, target and link from the presented operands
    // ------------------------------------------------------------------
    logic                accept_p0;
    logic                taken_p0;
    logic [DATA_LEN-1:0] target_p0;
    logic [DATA_LEN-1:0] link_p0;

    assign accept_p0 = valid_ex1 && ready_ex1 && !flush;
    assign taken_p0  = br_taken(br_func_ex1, rs1_ex1, rs2_ex1);
    assign target_p0 = br_target(br_func_ex1, pc_ex1, rs1_ex1, imm_ex1);
    assign link_p0   = pc_ex1 + DATA_LEN'(4);

    // ------------------------------------------------------------------
    // EX2 (p1): registered resolution, prediction check
    // ------------------------------------------------------------------
    logic                   vld_p1;
    logic [ROB_TAG_LEN-1:0] tag_p1;
    logic                   taken_p1;
    logic [DATA_LEN-1:0]    target_p1;
    logic [DATA_LEN-1:0]    link_p1;
    logic                   pred_taken_p1;
    logic [DATA_LEN-1:0]    pred_target_p1;

    // EX2 occupancy: flush kills the in-flight op and any same-cycle accept.
    always_ff @(posedge clk_free_master or posedge global_rst) begin
        if (global_rst) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept_p0;
        end
    end

    // EX2 payload, captured only on accept; qualified by vld_p1.
    always_ff @(posedge clk_free_master) begin
        if (accept_p0) begin
            tag_p1         <= rob_tag_ex1;
            taken_p1       <= taken_p0;
            target_p1      <= target_p0;
            link_p1        <= link_p0;
            pred_taken_p1  <= pred_taken_ex1;
            pred_target_p1 <= pred_target_ex1;
        end
    end

    logic [DATA_LEN-1:0] next_pc_p1;
    logic                mispredict_p1;
    logic                misalign_p1;
    logic [ENTRY_W-1:0]  entry_p1;

    // A misaligned taken target still reports its mispredict; the ROB sorts
    // out which exception wins.
    assign next_pc_p1    = taken_p1 ? target_p1 : link_p1;
    assign mispredict_p1 = (pred_taken_p1 != taken_p1) ||
                           (taken_p1 && (pred_target_p1 != target_p1));
    assign misalign_p1   = taken_p1 && (target_p1[1:0] != 2'b00);
    assign entry_p1      = {tag_p1, taken_p1, next_pc_p1, link_p1,
                            mispredict_p1, misalign_p1};

    // ------------------------------------------------------------------
    // FIFO (p2): in-order result buffer, head drives res_*
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   credit_used;
    logic [ENTRY_W-1:0] head_p2;

    assign push = vld_p1;
    assign pop  = res_valid && res_ready;

    // Pointer/count bookkeeping; flush empties the buffer and drops any
    // same-cycle push or pop.
    always_ff @(posedge clk_free_master or posedge global_rst) begin
        if (global_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Result storage; the credit rule guarantees a free slot for every push.
    always_ff @(posedge clk_free_master) begin
        if (push) begin
            fifo_mem[wr_ptr] <= entry_p1;
        end
    end

    // Outputs are forced to zero when empty so reset and flush present a
    // clean, all-zero result bus without resetting the storage itself.
    assign res_valid = (count != '0);
    assign head_p2   = res_valid ? fifo_mem[rd_ptr] : '0;
    assign {res_tag, res_taken, res_next_pc, res_link,
            res_mispredict, res_misalign} = head_p2;

    // Credits count the FIFO plus the op in EX2; this cycle's pop is not
    // credited, so EX2 can always push without stalling.
    assign credit_used = count + CNT_W'(vld_p1);
    assign ready_ex1   = !global_rst && (credit_used < CNT_W'(OUT_DEPTH));

endmodule

// File: tb/tb_beu_pipe.sv
// tb_beu_pipe: directed scenarios plus randomized traffic checked against a
// queue-based reference model of the branch unit.
module tb_beu_pipe;

    localparam int DL = 32;
    localparam int TL = 6;
    localparam int OD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          valid = 1'b0;
    logic          ready;
    logic [2:0]    func = '0;
    logic [DL-1:0] pc = '0, rs1 = '0, rs2 = '0, imm = '0, ptgt = '0;
    logic          pt = 1'b0;
    logic [TL-1:0] tag = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [TL-1:0] res_tag;
    logic          res_taken;
    logic [DL-1:0] res_next_pc, res_link;
    logic          res_mispredict, res_misalign;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [TL-1:0] tag;
        logic          taken;
        logic [DL-1:0] npc;
        logic [DL-1:0] link;
        logic          misp;
        logic          mis;
        logic [DL-1:0] tgt;
        int            acc;
    } exp_t;

    exp_t q[$];

    beu_pipe #(.DATA_LEN(DL), .ROB_TAG_LEN(TL), .OUT_DEPTH(OD)) dut (
        .clk_free_master(clk),
        .global_rst     (rst),
        .flush          (flush),
        .valid_ex1      (valid),
        .ready_ex1      (ready),
        .br_func_ex1    (func),
        .pc_ex1         (pc),
        .rs1_ex1        (rs1),
        .rs2_ex1        (rs2),
        .imm_ex1        (imm),
        .pred_taken_ex1 (pt),
        .pred_target_ex1(ptgt),
        .rob_tag_ex1    (tag),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_tag        (res_tag),
        .res_taken      (res_taken),
        .res_next_pc    (res_next_pc),
        .res_link       (res_link),
        .res_mispredict (res_mispredict),
        .res_misalign   (res_misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: architectural branch semantics in plain arithmetic.
    function automatic exp_t model(input logic [2:0] f, input logic [DL-1:0] p,
                                   input logic [DL-1:0] a, input logic [DL-1:0] b,
                                   input logic [DL-1:0] im, input logic pti,
                                   input logic [DL-1:0] pg, input logic [TL-1:0] tg);
        exp_t e;
        e = '0;
        case (f)
            3'd0:    e.taken = (a == b);
            3'd1:    e.taken = (a != b);
            3'd4:    e.taken = ($signed(a) < $signed(b));
            3'd5:    e.taken = ($signed(a) >= $signed(b));
            3'd6:    e.taken = (a < b);
            3'd7:    e.taken = (a >= b);
            default: e.taken = 1'b1;
        endcase
        if (f == 3'd3) e.tgt = (a + im) & ~32'd1;
        else           e.tgt = p + im;
        e.link = p + 32'd4;
        e.npc  = e.taken ? e.tgt : e.link;
        e.misp = (pti != e.taken) || (e.taken && (pg != e.tgt));
        e.mis  = e.taken && (e.tgt[1:0] != 2'b00);
        e.tag  = tg;
        return e;
    endfunction

    task automatic drive(input logic [2:0] f, input logic [DL-1:0] p,
                         input logic [DL-1:0] a, input logic [DL-1:0] b,
                         input logic [DL-1:0] im, input logic pti,
                         input logic [DL-1:0] pg, input logic [TL-1:0] tg);
        valid = 1'b1; func = f; pc = p; rs1 = a; rs2 = b; imm = im;
        pt = pti; ptgt = pg; tag = tg;
    endtask

    task automatic pop_one();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign} !== '0)
            $display("FAIL reset_outputs got=%h want=0", {res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign});
        else n_pass++;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", ready); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL post_reset_ready got=%b want=1", ready); else n_pass++;
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL post_reset_valid got=%b want=0", res_valid); else n_pass++;
    endtask

    task automatic test_beq();
        logic [72:0] snap;
        drive(3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120, 6'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL beq_latency1 got=%b want=0", res_valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (res_valid !== 1'b1) $display("FAIL beq_latency2 got=%b want=1", res_valid); else n_pass++;
        snap = {res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign};
        n_checks++;
        if (snap !== {6'd1, 1'b1, 32'h120, 32'h104, 1'b0, 1'b0})
            $display("FAIL beq_result got=%h want=%h", snap, {6'd1, 1'b1, 32'h120, 32'h104, 1'b0, 1'b0});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign} !== {1'b1, 6'd1, 1'b1, 32'h120, 32'h104, 1'b0, 1'b0})
            $display("FAIL beq_hold got=%h want=%h", {res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign}, snap);
        else n_pass++;
        pop_one();
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL beq_pop got=%b want=0", res_valid); else n_pass++;
    endtask

    task automatic test_signed_unsigned();
        drive(3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h240, 6'd2);
        @(posedge clk); #1;
        drive(3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h240, 6'd3);
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign} !== {1'b1, 6'd2, 1'b1, 32'h240, 32'h204, 1'b0, 1'b0})
            $display("FAIL blt_result got=%h want=%h", {res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign}, {1'b1, 6'd2, 1'b1, 32'h240, 32'h204, 1'b0, 1'b0});
        else n_pass++;
        pop_one();
        n_checks++;
        if ({res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign} !== {1'b1, 6'd3, 1'b0, 32'h204, 32'h204, 1'b1, 1'b0})
            $display("FAIL bltu_result got=%h want=%h", {res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign}, {1'b1, 6'd3, 1'b0, 32'h204, 32'h204, 1'b1, 1'b0});
        else n_pass++;
        pop_one();
    endtask

    task automatic test_jumps();
        drive(3'b011, 32'h300, 32'h203, 32'd0, 32'd0, 1'b1, 32'h202, 6'd4);
        @(posedge clk); #1;
        drive(3'b010, 32'h100, 32'd0, 32'd0, 32'h6, 1'b0, 32'h0, 6'd5);
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign} !== {1'b1, 6'd4, 1'b1, 32'h202, 32'h304, 1'b0, 1'b1})
            $display("FAIL jalr_result got=%h want=%h", {res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign}, {1'b1, 6'd4, 1'b1, 32'h202, 32'h304, 1'b0, 1'b1});
        else n_pass++;
        pop_one();
        n_checks++;
        if ({res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign} !== {1'b1, 6'd5, 1'b1, 32'h106, 32'h104, 1'b1, 1'b1})
            $display("FAIL jal_result got=%h want=%h", {res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign}, {1'b1, 6'd5, 1'b1, 32'h106, 32'h104, 1'b1, 1'b1});
        else n_pass++;
        pop_one();
    endtask

    task automatic test_backpressure();
        int acc;
        int idx;
        bit first;
        acc = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(3'b001, 32'h1000, 32'd1, 32'd2, 32'h8, 1'b1, 32'h1008, TL'(acc));
            @(negedge clk);
            if (ready) acc++;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        n_checks++;
        if (acc !== OD) $display("FAIL bp_accepts got=%0d want=%0d", acc, OD); else n_pass++;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL bp_full_ready got=%b want=0", ready); else n_pass++;
        res_ready = 1'b1;
        idx = 0;
        first = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) begin
                n_checks++;
                if (res_tag !== TL'(idx)) $display("FAIL bp_order got=%0d want=%0d", res_tag, idx); else n_pass++;
                if (first) begin
                    n_checks++;
                    if (ready !== 1'b0) $display("FAIL bp_pop_not_credited got=%b want=0", ready); else n_pass++;
                    @(posedge clk); #1;
                    n_checks++;
                    if (ready !== 1'b1) $display("FAIL bp_credit_return got=%b want=1", ready); else n_pass++;
                    first = 1'b0;
                    idx++;
                    continue;
                end
                idx++;
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        n_checks++;
        if (idx !== OD) $display("FAIL bp_drained got=%0d want=%0d", idx, OD); else n_pass++;
    endtask

    task automatic test_flush();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 32'h2000, 32'd7, 32'd7, 32'h10, 1'b1, 32'h2010, TL'(10 + i));
            @(posedge clk); #1;
        end
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (res_valid !== 1'b1) $display("FAIL flush_prefill got=%b want=1", res_valid); else n_pass++;
        drive(3'b000, 32'h2100, 32'd7, 32'd7, 32'h10, 1'b1, 32'h2110, 6'd13);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        valid = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL flush_valid got=%b want=0", res_valid); else n_pass++;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL flush_ready got=%b want=1", ready); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL flush_discard got=%b want=0", res_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 32'h400, 32'd1, 32'd1, 32'h8, 1'b1, 32'h408, TL'(20 + i));
            @(posedge clk); #1;
        end
        n_checks++;
        if (res_valid !== 1'b1) $display("FAIL midrst_prefill got=%b want=1", res_valid); else n_pass++;
        #2 rst = 1'b1;
        #1;
        valid = 1'b0;
        n_checks++;
        if ({res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign, ready} !== '0)
            $display("FAIL midrst_async got=%h want=0", {res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign, ready});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL midrst_ready got=%b want=1", ready); else n_pass++;
        drive(3'b001, 32'h500, 32'd1, 32'd2, 32'h10, 1'b1, 32'h510, 6'd30);
        @(posedge clk); #1;
        valid = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL midrst_lat1 got=%b want=0", res_valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign} !== {1'b1, 6'd30, 1'b1, 32'h510, 32'h504, 1'b0, 1'b0})
            $display("FAIL midrst_result got=%h want=%h", {res_valid, res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign}, {1'b1, 6'd30, 1'b1, 32'h510, 32'h504, 1'b0, 1'b0});
        else n_pass++;
        pop_one();
    endtask

    task automatic test_random();
        exp_t e;
        exp_t h;
        logic [TL-1:0] tctr;
        bit exp_valid;
        tctr = '0;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            if (c < 580) begin
                valid = ($urandom_range(0, 3) != 0);
                func  = 3'($urandom_range(0, 7));
                pc    = $urandom & 32'hFFFF_FFFC;
                rs1   = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
                case ($urandom_range(0, 3))
                    0:       rs2 = rs1;
                    1:       rs2 = rs1 + 32'd1;
                    2:       rs2 = rs1 - 32'd1;
                    default: rs2 = $urandom;
                endcase
                imm   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom_range(0, 511) - 32'd256);
                pt    = 1'($urandom_range(0, 1));
                tag   = tctr;
                e     = model(func, pc, rs1, rs2, imm, pt, 32'd0, tag);
                ptgt  = ($urandom_range(0, 1) == 0) ? e.tgt : $urandom;
                res_ready = ($urandom_range(0, 3) != 0);
                flush = ($urandom_range(0, 40) == 0);
            end else begin
                valid = 1'b0;
                res_ready = 1'b1;
                flush = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (ready !== (q.size() < OD)) $display("FAIL rand_ready got=%b want=%b", ready, (q.size() < OD)); else n_pass++;
            exp_valid = (q.size() > 0) && (q[0].acc + 1 <= cyc);
            n_checks++;
            if (res_valid !== exp_valid) $display("FAIL rand_valid got=%b want=%b", res_valid, exp_valid); else n_pass++;
            if (flush) begin
                q.delete();
            end else begin
                if (res_valid && res_ready && q.size() > 0) begin
                    h = q.pop_front();
                    n_checks++;
                    if ({res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign} !== {h.tag, h.taken, h.npc, h.link, h.misp, h.mis})
                        $display("FAIL rand_result got=%h want=%h", {res_tag, res_taken, res_next_pc, res_link, res_mispredict, res_misalign}, {h.tag, h.taken, h.npc, h.link, h.misp, h.mis});
                    else n_pass++;
                end
                if (valid && ready) begin
                    e = model(func, pc, rs1, rs2, imm, pt, ptgt, tag);
                    e.acc = cyc + 1;
                    q.push_back(e);
                    tctr = tctr + TL'(1);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (q.size() !== 0) $display("FAIL rand_drain got=%0d want=0", q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_jumps();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
